// File: rtl/np_pkg.sv
// Shared types and activation helpers for the neural_processor sequencer.
// Optional feature macro: NP_LINEAR_ACT_EN (selects the saturating identity activation).
package np_pkg;

    typedef enum logic [1:0] {
        OP_IN  = 2'b00,
        OP_MAC = 2'b01,
        OP_ACT = 2'b10,
        OP_FIN = 2'b11
    } op_e;

    typedef struct packed {
        logic signed [15:0] value;
        logic        [15:0] lifetime;
    } entry_t;

    localparam logic [1:0] SRC_INPUT = 2'd2;
    localparam logic [1:0] SRC_WORK  = 2'd1;

    // Sigmoid approximation: clamp to 10-bit signed, quarter it, bias by 128 (0.5 at zero).
    function automatic logic signed [15:0] act_sigmoid(input logic signed [31:0] x);
        logic signed [9:0] s;
        logic signed [9:0] sh;
        if (x > 32'sd511) begin
            s = 10'b01_1111_1111;
        end else if (x < -32'sd512) begin
            s = 10'b10_0000_0000;
        end else begin
            s = x[9:0];
        end
        sh = s >>> 2;
        return $signed({{6{sh[9]}}, sh}) + 16'sd128;
    endfunction

    // Identity activation saturated to the 16-bit signed entry value range.
    function automatic logic signed [15:0] act_linear(input logic signed [31:0] x);
        logic signed [15:0] y;
        if (x > 32'sd32767) begin
            y = 16'sh7FFF;
        end else if (x < -32'sd32768) begin
            y = 16'sh8000;
        end else begin
            y = x[15:0];
        end
        return y;
    endfunction

endpackage

// File: rtl/np_fifo.sv
// Circular FIFO of entry_t with one-slot-empty full detection and legal same-cycle push+pop.
// Storage is not reset so preloaded contents survive a reset of the pointers.
module np_fifo
    import np_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  logic   pop_i,
    input  entry_t wdata_i,
    output entry_t data_out_o,
    output logic   empty_o,
    output logic   full_o
);
    localparam int AW = $clog2(DEPTH);

    entry_t        data_array [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_d;
    logic [AW-1:0] tail_d;
    entry_t        data_out;
    logic          empty;
    logic          full;

    assign data_out   = data_array[head];
    assign empty      = (head == tail);
    assign full       = (AW'(tail + AW'(1'b1)) == head);
    assign data_out_o = data_out;
    assign empty_o    = empty;
    assign full_o     = full;

    // Next pointer values; each pointer advances independently and wraps modulo DEPTH.
    always_comb begin
        head_d = head;
        tail_d = tail;
        if (pop_i) begin
            head_d = AW'(head + AW'(1'b1));
        end else begin
            head_d = head;
        end
        if (push_i) begin
            tail_d = AW'(tail + AW'(1'b1));
        end else begin
            tail_d = tail;
        end
    end

    // Entry storage write at the tail slot.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            data_array[tail] <= wdata_i;
        end
    end

    // Head/tail pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head_d;
            tail <= tail_d;
        end
    end

endmodule

// File: rtl/neural_processor.sv
// Single-issue neural-net sequencer: pc counts down through instr_mem, MACs source-FIFO
// activations against immediate weights, then activates and queues results.
// Optional feature macro: NP_LINEAR_ACT_EN (saturating identity instead of sigmoid approx).
module neural_processor
    import np_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024,
    parameter int FIFO_DEPTH = 1024,
    parameter int START_PC   = 0
) (
    input logic clk,
    input logic reset
);
    localparam int PC_W = $clog2(IMEM_DEPTH);

    logic [PC_W-1:0]    pc_out;
    logic [PC_W-1:0]    pc_d;
    logic signed [31:0] acc_q;
    logic signed [31:0] acc_d;
    logic [1:0]         src_sel_q;
    logic [1:0]         src_sel_d;
    logic               halted_q;
    logic               halted_d;

    logic [31:0] instr_s;
    logic [15:0] imm_s;
    op_e         op_s;
    entry_t      in_dout_s, work_dout_s, out_dout_s, src_head_s;
    entry_t      recirc_entry_s, act_entry_s, work_wdata_s;
    logic        in_empty_s, work_empty_s, out_empty_s;
    logic        in_full_s, work_full_s, out_full_s;
    logic        in_push_s, in_pop_s, work_push_s, work_pop_s, out_push_s;
    logic        src_is_work_s, src_empty_s, dest_full_s, recirc_s, stall_s;
    logic        unused_bits_s;

    // Program store, loaded from outside before reset release.
    if (1) begin : instr_mem
        logic [31:0] data_array [IMEM_DEPTH] = '{default: 32'd0};
    end

    // Reset value of the program counter; may be rewritten before reset release.
    if (1) begin : pc
        logic [PC_W-1:0] start = PC_W'(START_PC);
    end

    assign instr_s = instr_mem.data_array[pc_out];
    assign imm_s   = instr_s[15:0];

    if (1) begin : neural_controller
        op_e opcode;
        assign opcode = op_e'(instr_s[31:30]);
    end
    assign op_s = neural_controller.opcode;

    assign src_is_work_s = (src_sel_q == SRC_WORK);
    assign src_head_s    = src_is_work_s ? work_dout_s : in_dout_s;
    assign src_empty_s   = src_is_work_s ? work_empty_s : in_empty_s;
    assign dest_full_s   = (imm_s != 16'd0) ? work_full_s : out_full_s;
    assign recirc_s      = (src_head_s.lifetime > 16'd1);
    assign stall_s       = halted_q
                         | ((op_s == OP_MAC) & src_empty_s)
                         | ((op_s == OP_ACT) & dest_full_s);

    if (1) begin : multadd
        logic signed [15:0] in0;
        logic signed [15:0] in1;
        logic signed [31:0] in_acc;
        logic signed [31:0] out;
        assign in0    = src_head_s.value;
        assign in1    = $signed(imm_s);
        assign in_acc = acc_q;
        assign out    = in_acc + (32'(in0) * 32'(in1));
    end

    if (1) begin : transfer_function
        logic signed [31:0] x;
        logic signed [15:0] y;
        assign x = acc_q;
`ifdef NP_LINEAR_ACT_EN
        assign y = act_linear(x);
`else
        assign y = act_sigmoid(x);
`endif
    end

    assign recirc_entry_s.value    = src_head_s.value;
    assign recirc_entry_s.lifetime = src_head_s.lifetime - 16'd1;
    // imm doubles as the lifetime; for output-FIFO pushes it is zero.
    assign act_entry_s.value       = transfer_function.y;
    assign act_entry_s.lifetime    = imm_s;
    assign work_wdata_s            = (op_s == OP_ACT) ? act_entry_s : recirc_entry_s;

    // Decode and execute one instruction unless stalled or halted.
    always_comb begin
        pc_d        = pc_out;
        acc_d       = acc_q;
        src_sel_d   = src_sel_q;
        halted_d    = halted_q;
        in_push_s   = 1'b0;
        in_pop_s    = 1'b0;
        work_push_s = 1'b0;
        work_pop_s  = 1'b0;
        out_push_s  = 1'b0;
        if (stall_s) begin
            pc_d = pc_out;
        end else begin
            case (op_s)
                OP_IN: begin
                    if (imm_s == {14'd0, SRC_INPUT}) begin
                        src_sel_d = SRC_INPUT;
                    end else if (imm_s == {14'd0, SRC_WORK}) begin
                        src_sel_d = SRC_WORK;
                    end else begin
                        src_sel_d = src_sel_q;
                    end
                end
                OP_MAC: begin
                    acc_d = multadd.out;
                    if (src_is_work_s) begin
                        work_pop_s  = 1'b1;
                        work_push_s = recirc_s;
                    end else begin
                        in_pop_s  = 1'b1;
                        in_push_s = recirc_s;
                    end
                end
                OP_ACT: begin
                    acc_d = 32'sd0;
                    if (imm_s != 16'd0) begin
                        work_push_s = 1'b1;
                    end else begin
                        out_push_s = 1'b1;
                    end
                end
                default: begin
                    halted_d = 1'b1;
                end
            endcase
            // Executing any non-finish instruction at address 0 halts instead of wrapping.
            if (op_s == OP_FIN) begin
                pc_d = pc_out;
            end else if (pc_out == '0) begin
                halted_d = 1'b1;
            end else begin
                pc_d = pc_out - PC_W'(1'b1);
            end
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out    <= pc.start;
            acc_q     <= 32'sd0;
            src_sel_q <= SRC_INPUT;
            halted_q  <= 1'b0;
        end else begin
            pc_out    <= pc_d;
            acc_q     <= acc_d;
            src_sel_q <= src_sel_d;
            halted_q  <= halted_d;
        end
    end

    np_fifo #(.DEPTH(FIFO_DEPTH)) input_fifo (
        .clk_i(clk), .rst_ni(reset), .push_i(in_push_s), .pop_i(in_pop_s),
        .wdata_i(recirc_entry_s), .data_out_o(in_dout_s), .empty_o(in_empty_s), .full_o(in_full_s)
    );

    np_fifo #(.DEPTH(FIFO_DEPTH)) work_fifo (
        .clk_i(clk), .rst_ni(reset), .push_i(work_push_s), .pop_i(work_pop_s),
        .wdata_i(work_wdata_s), .data_out_o(work_dout_s), .empty_o(work_empty_s), .full_o(work_full_s)
    );

    np_fifo #(.DEPTH(FIFO_DEPTH)) output_fifo (
        .clk_i(clk), .rst_ni(reset), .push_i(out_push_s), .pop_i(1'b0),
        .wdata_i(act_entry_s), .data_out_o(out_dout_s), .empty_o(out_empty_s), .full_o(out_full_s)
    );

    // Instruction bits 29:16, the output FIFO head and the input FIFO full flag have no consumer.
    assign unused_bits_s = ^{instr_s[29:16], out_dout_s, in_full_s, out_empty_s};

endmodule

// File: tb/tb_neural_processor.sv
// Self-checking bench for neural_processor: expected FIFO pushes are queued when a program
// is loaded and compared as the DUT pushes them; state is spot-checked at key points.
`timescale 1ns/1ps
module tb_neural_processor;
    import np_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] exp_work [$];
    logic [31:0] exp_out  [$];
    logic [9:0]  wtail;
    logic [9:0]  otail;
    int          l2;

    neural_processor #(.IMEM_DEPTH(1024), .FIFO_DEPTH(1024), .START_PC(0)) dut (
        .clk  (clk),
        .reset(reset)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [1:0] op, input logic [15:0] imm);
        return {op, 14'd0, imm};
    endfunction

    function automatic logic [31:0] ent(input int v, input int l);
        return {16'(v), 16'(l)};
    endfunction

    // Reference activation model.
    function automatic int act_ref(input int a);
        int s;
`ifdef NP_LINEAR_ACT_EN
        s = (a > 32767) ? 32767 : ((a < -32768) ? -32768 : a);
        return s;
`else
        s = (a > 511) ? 511 : ((a < -512) ? -512 : a);
        return (s >>> 2) + 128;
`endif
    endfunction

    // One clock; then compare any new FIFO push against the scoreboard.
    task automatic step();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (dut.work_fifo.tail != wtail) begin
            if (exp_work.size() != 0) e = exp_work.pop_front();
            else e = 32'hDEAD_BEEF;
            check_eq("work_push", dut.work_fifo.data_array[wtail], e);
            wtail = dut.work_fifo.tail;
        end
        if (dut.output_fifo.tail != otail) begin
            if (exp_out.size() != 0) e = exp_out.pop_front();
            else e = 32'hDEAD_BEEF;
            check_eq("out_push", dut.output_fifo.data_array[otail], e);
            otail = dut.output_fifo.tail;
        end
    endtask

    task automatic do_reset(input logic [9:0] start, input logic [9:0] in_tail);
        @(negedge clk);
        reset = 1'b0;
        dut.pc.start = start;
        exp_work.delete();
        exp_out.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dut.input_fifo.tail = in_tail;
        wtail = 10'd0;
        otail = 10'd0;
    endtask

    task automatic load_reference();
        logic [31:0] prog [14];
        // Listed from address 13 down to 0.
        prog = '{ins(OP_IN, 16'd2), ins(OP_MAC, 16'd3), ins(OP_MAC, 16'd5), ins(OP_MAC, 16'd7),
                 ins(OP_ACT, 16'd1), ins(OP_MAC, 16'd9), ins(OP_MAC, 16'd11), ins(OP_MAC, 16'd13),
                 ins(OP_ACT, 16'd1), ins(OP_IN, 16'd1), ins(OP_MAC, 16'd15), ins(OP_MAC, 16'd1),
                 ins(OP_ACT, 16'd0), ins(OP_FIN, 16'd0)};
        for (int i = 0; i < 14; i++) dut.instr_mem.data_array[13 - i] = prog[i];
        dut.input_fifo.data_array[0] = ent(4, 2);
        dut.input_fifo.data_array[1] = ent(4, 2);
        dut.input_fifo.data_array[2] = ent(5, 2);
    endtask

    initial begin
        wtail = 10'd0;
        otail = 10'd0;
        l2 = act_ref(67) * 15 + act_ref(145);

        // ---------------- reference program ----------------
        load_reference();
        do_reset(10'd13, 10'd3);
        check_eq("rst_pc", 32'(dut.pc_out), 32'd13);
        check_eq("rst_acc", dut.multadd.in_acc, 32'd0);
        check_eq("rst_halted", 32'(dut.halted_q), 32'd0);
        check_eq("rst_work_empty", 32'(dut.work_fifo.empty), 32'd1);
        check_eq("rst_out_empty", 32'(dut.output_fifo.empty), 32'd1);
        check_eq("first_opcode", 32'(dut.neural_controller.opcode), 32'(OP_IN));
        exp_work.push_back(ent(act_ref(67), 1));
        exp_work.push_back(ent(act_ref(145), 1));
        exp_out.push_back(ent(act_ref(l2), 0));

        repeat (4) step();
        check_eq("l1a_acc", dut.multadd.in_acc, 32'(4*3 + 4*5 + 5*7));
        check_eq("l1a_head", 32'(dut.input_fifo.head), 32'd3);
        check_eq("l1a_tail", 32'(dut.input_fifo.tail), 32'd6);
        check_eq("recirc0", dut.input_fifo.data_array[3], ent(4, 1));
        check_eq("recirc1", dut.input_fifo.data_array[4], ent(4, 1));
        check_eq("recirc2", dut.input_fifo.data_array[5], ent(5, 1));
        step();
        check_eq("a1_acc_clear", dut.multadd.in_acc, 32'd0);
        repeat (3) step();
        check_eq("l1b_acc", dut.multadd.in_acc, 32'(4*9 + 4*11 + 5*13));
        check_eq("l1b_in_empty", 32'(dut.input_fifo.empty), 32'd1);
        step();
        check_eq("a1b_acc_clear", dut.multadd.in_acc, 32'd0);
        repeat (3) step();
        check_eq("l2_acc", dut.multadd.in_acc, 32'(l2));
        step();
        check_eq("pre_fin_pc", 32'(dut.pc_out), 32'd0);
        check_eq("pre_fin_halted", 32'(dut.halted_q), 32'd0);
        step();
        check_eq("fin_halted", 32'(dut.halted_q), 32'd1);
        repeat (3) step();
        check_eq("fin_pc_hold", 32'(dut.pc_out), 32'd0);
        check_eq("fin_out_tail", 32'(dut.output_fifo.tail), 32'd1);
        check_eq("ref_work_left", 32'(exp_work.size()), 32'd0);
        check_eq("ref_out_left", 32'(exp_out.size()), 32'd0);

        // ---------------- mid-run reset during layer 2 ----------------
        load_reference();
        do_reset(10'd13, 10'd3);
        exp_work.push_back(ent(act_ref(67), 1));
        exp_work.push_back(ent(act_ref(145), 1));
        repeat (11) step();
        #2;
        reset = 1'b0;
        #1;
        check_eq("mrst_pc", 32'(dut.pc_out), 32'd13);
        check_eq("mrst_acc", dut.multadd.in_acc, 32'd0);
        check_eq("mrst_halted", 32'(dut.halted_q), 32'd0);
        check_eq("mrst_in_empty", 32'(dut.input_fifo.empty), 32'd1);
        check_eq("mrst_work_empty", 32'(dut.work_fifo.empty), 32'd1);
        check_eq("mrst_out_empty", 32'(dut.output_fifo.empty), 32'd1);
        check_eq("mrst_data_kept", dut.work_fifo.data_array[0], ent(act_ref(67), 1));
        check_eq("mrst_work_left", 32'(exp_work.size()), 32'd0);

        // ---------------- empty-source stall ----------------
        load_reference();
        do_reset(10'd13, 10'd0);
        step();
        check_eq("stall_enter_pc", 32'(dut.pc_out), 32'd12);
        repeat (4) step();
        check_eq("stall_pc", 32'(dut.pc_out), 32'd12);
        check_eq("stall_acc", dut.multadd.in_acc, 32'd0);
        dut.input_fifo.tail = 10'd1;
        step();
        check_eq("resume_pc", 32'(dut.pc_out), 32'd11);
        check_eq("resume_acc", dut.multadd.in_acc, 32'd12);

        // ---------------- clamping and halt after non-finish at address 0 ----------------
        dut.instr_mem.data_array[6] = ins(OP_IN, 16'd2);
        dut.instr_mem.data_array[5] = ins(OP_MAC, 16'hFFFD);
        dut.instr_mem.data_array[4] = ins(OP_ACT, 16'd0);
        dut.instr_mem.data_array[3] = ins(OP_MAC, 16'hFF9C);
        dut.instr_mem.data_array[2] = ins(OP_ACT, 16'd0);
        dut.instr_mem.data_array[1] = ins(OP_MAC, 16'd2);
        dut.instr_mem.data_array[0] = ins(OP_ACT, 16'd0);
        dut.input_fifo.data_array[0] = ent(100, 1);
        dut.input_fifo.data_array[1] = ent(100, 1);
        dut.input_fifo.data_array[2] = ent(30000, 1);
        do_reset(10'd6, 10'd3);
        exp_out.push_back(ent(act_ref(-300), 0));
        exp_out.push_back(ent(act_ref(-10000), 0));
        exp_out.push_back(ent(act_ref(60000), 0));
        repeat (7) step();
        check_eq("zero_halted", 32'(dut.halted_q), 32'd1);
        repeat (3) step();
        check_eq("zero_pc_hold", 32'(dut.pc_out), 32'd0);
        check_eq("zero_out_tail", 32'(dut.output_fifo.tail), 32'd3);
        check_eq("zero_in_empty", 32'(dut.input_fifo.empty), 32'd1);
        check_eq("clamp_out_left", 32'(exp_out.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
